// File: rtl/mwrxpkt_pkg.sv
// Shared definitions for the receive packet processor and its payload RAM.
package mwrxpkt_pkg;

    // Number of UDP port header bytes emitted ahead of every payload.
    localparam int HDR_BYTES = 4;

    // Buffer pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Read-side sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } rd_state_e;

endpackage

// File: rtl/mwrxpktram.sv
// Simple dual-port packet RAM: one write port, one registered read port.
module mwrxpktram #(
    parameter int WIDTH = 9,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**AW];

    // Write on request; read data appears the cycle after re and then holds.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mwrxpktproc.sv
// Receive packet processor: store-and-forward buffer for UDP payloads.
// Good packets are replayed as a 4-byte port header followed by the payload;
// errored or overflowing packets are rewound away and counted.
module mwrxpktproc
    import mwrxpkt_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 11,
    parameter int HDRQ_AW   = 2
) (
    input  logic                 rxclk,
    input  logic                 rxrst_n,
    input  logic [DATAWIDTH-1:0] rxdata,
    input  logic                 rxdatavalid,
    input  logic                 rxeop,
    input  logic                 rxerr,
    input  logic [31:0]          udpport_4,
    input  logic                 rxbuffer_rden,
    output logic [DATAWIDTH-1:0] rxbuffer_data,
    output logic                 rxbuffer_datavld,
    output logic                 rxbuffer_eop,
    output logic                 rxbuffer_pktavail,
    output logic [15:0]          rxdrop_cnt
);

    localparam int PTR_W    = ptr_width(ADDRWIDTH);
    localparam int HQ_PW    = HDRQ_AW + 1;
    localparam int HQ_DEPTH = 1 << HDRQ_AW;

    // Reset synchronizer
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n_int;

    // Write side
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] commit_ptr_q, commit_ptr_d;
    logic             sop_q, sop_d;
    logic             drop_q, drop_d;
    logic [31:0]      port_lat_q, port_lat_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             drop_now;
    logic             buf_full;
    logic             ram_we;

    // Header queue
    logic [31:0]      hdrq_q [HQ_DEPTH];
    logic [31:0]      hdrq_d [HQ_DEPTH];
    logic [HQ_PW-1:0] hq_wp_q, hq_wp_d;
    logic [HQ_PW-1:0] hq_rp_q, hq_rp_d;
    logic             hq_full;
    logic             hq_empty;
    logic             hq_push;
    logic             hq_pop;
    logic [31:0]      push_port;
    logic [31:0]      hdr_word;

    // Read side
    rd_state_e            state_q, state_d;
    logic [1:0]           hcnt_q, hcnt_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic                 datavld_q, datavld_d;
    logic                 src_pl_q, src_pl_d;
    logic [DATAWIDTH-1:0] hdr_byte_q, hdr_byte_d;
    logic [7:0]           hdr_sel;
    logic                 ram_re;
    logic                 eop_presented;
    logic [DATAWIDTH:0]   ram_rdata;

    // Release internal reset two clocks after rxrst_n rises; assert at once.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchronizer register
    always_ff @(posedge rxclk or negedge rxrst_n) begin
        if (!rxrst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n_int = rst_sync_q[1];

    assign buf_full = (wr_ptr_q - rd_ptr_q) == {1'b1, {ADDRWIDTH{1'b0}}};
    assign hq_full  = (hq_wp_q - hq_rp_q) == {1'b1, {HDRQ_AW{1'b0}}};
    assign hq_empty = (hq_wp_q == hq_rp_q);
    assign hdr_word = hdrq_q[hq_rp_q[HDRQ_AW-1:0]];

    // Write side: store bytes, then commit or rewind the packet at EOP.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        sop_d        = sop_q;
        drop_d       = drop_q;
        port_lat_d   = port_lat_q;
        drop_cnt_d   = drop_cnt_q;
        ram_we       = 1'b0;
        hq_push      = 1'b0;
        push_port    = port_lat_q;
        drop_now     = 1'b0;
        if (rxdatavalid) begin
            push_port = sop_q ? udpport_4 : port_lat_q;
            drop_now  = drop_q | (sop_q & hq_full) | buf_full;
            if (sop_q) begin
                port_lat_d = udpport_4;
            end
            if (!drop_now) begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rxeop) begin
                sop_d  = 1'b1;
                drop_d = 1'b0;
                if (rxerr || drop_now) begin
                    wr_ptr_d = commit_ptr_q;
                    if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end else begin
                    commit_ptr_d = wr_ptr_q + PTR_W'(1);
                    hq_push      = 1'b1;
                end
            end else begin
                sop_d  = 1'b0;
                drop_d = drop_now;
            end
        end
    end

    // Header queue: push the port of each committed packet, pop when its EOP leaves.
    always_comb begin
        hdrq_d  = hdrq_q;
        hq_wp_d = hq_wp_q;
        hq_rp_d = hq_rp_q;
        if (hq_push) begin
            hdrq_d[hq_wp_q[HDRQ_AW-1:0]] = push_port;
            hq_wp_d = hq_wp_q + HQ_PW'(1);
        end
        if (hq_pop) begin
            hq_rp_d = hq_rp_q + HQ_PW'(1);
        end
    end

    // Select the header byte for the current header count, MSB first.
    always_comb begin
        case (hcnt_q)
            2'd0:    hdr_sel = hdr_word[31:24];
            2'd1:    hdr_sel = hdr_word[23:16];
            2'd2:    hdr_sel = hdr_word[15:8];
            default: hdr_sel = hdr_word[7:0];
        endcase
    end

    assign eop_presented = datavld_q & src_pl_q & ram_rdata[DATAWIDTH];

    // Read sequencer: header bytes from the queue head, then payload until EOP.
    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        rd_ptr_d   = rd_ptr_q;
        datavld_d  = 1'b0;
        src_pl_d   = 1'b0;
        hdr_byte_d = hdr_byte_q;
        ram_re     = 1'b0;
        hq_pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hq_empty) begin
                    state_d = HDR;
                    hcnt_d  = 2'd0;
                end
            end
            HDR: begin
                if (rxbuffer_rden) begin
                    datavld_d  = 1'b1;
                    hdr_byte_d = DATAWIDTH'(hdr_sel);
                    hcnt_d     = hcnt_q + 2'd1;
                    if (hcnt_q == 2'(HDR_BYTES - 1)) begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (eop_presented) begin
                    hq_pop  = 1'b1;
                    state_d = IDLE;
                end else if (rxbuffer_rden && (rd_ptr_q != commit_ptr_q)) begin
                    ram_re    = 1'b1;
                    rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                    datavld_d = 1'b1;
                    src_pl_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers for write side, header queue and read sequencer.
    always_ff @(posedge rxclk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            sop_q        <= 1'b1;
            drop_q       <= 1'b0;
            port_lat_q   <= '0;
            drop_cnt_q   <= '0;
            hdrq_q       <= '{default: '0};
            hq_wp_q      <= '0;
            hq_rp_q      <= '0;
            state_q      <= IDLE;
            hcnt_q       <= '0;
            rd_ptr_q     <= '0;
            datavld_q    <= 1'b0;
            src_pl_q     <= 1'b0;
            hdr_byte_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            sop_q        <= sop_d;
            drop_q       <= drop_d;
            port_lat_q   <= port_lat_d;
            drop_cnt_q   <= drop_cnt_d;
            hdrq_q       <= hdrq_d;
            hq_wp_q      <= hq_wp_d;
            hq_rp_q      <= hq_rp_d;
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            rd_ptr_q     <= rd_ptr_d;
            datavld_q    <= datavld_d;
            src_pl_q     <= src_pl_d;
            hdr_byte_q   <= hdr_byte_d;
        end
    end

    mwrxpktram #(
        .WIDTH(DATAWIDTH + 1),
        .AW   (ADDRWIDTH)
    ) u_ram (
        .clk  (rxclk),
        .we   (ram_we),
        .waddr(wr_ptr_q[ADDRWIDTH-1:0]),
        .wdata({rxeop, rxdata}),
        .re   (ram_re),
        .raddr(rd_ptr_q[ADDRWIDTH-1:0]),
        .rdata(ram_rdata)
    );

    // Outputs are forced to zero whenever no byte is being presented.
    assign rxbuffer_datavld  = datavld_q;
    assign rxbuffer_data     = datavld_q ? (src_pl_q ? ram_rdata[DATAWIDTH-1:0] : hdr_byte_q) : '0;
    assign rxbuffer_eop      = datavld_q & src_pl_q & ram_rdata[DATAWIDTH];
    assign rxbuffer_pktavail = !hq_empty;
    assign rxdrop_cnt        = drop_cnt_q;

endmodule

// File: doc/mwrxpktproc.md
Name: mwrxpktproc

Overview:
- Receive-direction packet processor between the UDP rxmac and the DUT-side arbiter.
- Stores each received UDP payload in a store-and-forward packet buffer; packets flagged with an error, or packets that overflow, are discarded.
- Re-emits each good packet to the arbiter as a 4-byte UDP port header (MSB first) followed by the payload, with EOP on the last payload byte.
- Single clock domain.

Parameters:
- DATAWIDTH, 8, byte width of data paths.
- ADDRWIDTH, 11, log2 of payload buffer depth in bytes (2048).
- HDRQ_AW, 2, log2 of header (port) queue depth (4 packets).

Ports:
- rxclk  input  1  receive clock; all logic on rising edge.
- rxrst_n  input  1  asynchronous, active-low reset.
- rxdata  input  DATAWIDTH  payload byte from rxmac.
- rxdatavalid  input  1  rxdata valid this cycle.
- rxeop  input  1  last byte of packet; qualified by rxdatavalid.
- rxerr  input  1  packet bad (CRC/length); sampled with rxeop.
- udpport_4  input  32  UDP port word; sampled with first valid byte of packet.
- rxbuffer_rden  input  1  arbiter requests one byte.
- rxbuffer_data  output  DATAWIDTH  byte to arbiter.
- rxbuffer_datavld  output  1  rxbuffer_data valid.
- rxbuffer_eop  output  1  last byte of packet; qualified by datavld.
- rxbuffer_pktavail  output  1  at least one complete packet is committed.
- rxdrop_cnt  output  16  saturating count of dropped packets.

Behaviour:
- Reset (async assert, sync release to internal logic):
  - All outputs 0.
  - wr_ptr, commit_ptr, rd_ptr, header-queue pointers and drop counter cleared.
  - Write side armed for SOP; read FSM in IDLE.
  - Any packet in flight when reset asserts is lost. After release, the first rxdatavalid is treated as SOP.
- Write side:
  - SOP = first valid byte after reset or after an EOP. At SOP, latch udpport_4.
  - If the header queue is full at SOP, set drop_flag for the whole packet.
  - Each valid byte is written as {rxeop, rxdata} at wr_ptr, then wr_ptr+1. Pointers are ADDRWIDTH+1 bits, wrap-around by MSB.
  - If the buffer is full (wr_ptr − rd_ptr == 2^ADDRWIDTH) on a valid byte: do not write, set drop_flag.
  - Once drop_flag is set, further bytes are not written until EOP.
  - At EOP:
    - If rxerr or drop_flag: wr_ptr <= commit_ptr, rxdrop_cnt+1 (saturating at 0xFFFF), clear drop_flag.
    - Else: commit_ptr <= wr_ptr+1 and push the latched port into the header queue on the same cycle.
  - A single-byte packet (SOP and EOP on the same cycle) is legal.
- Read side FSM:
  - States: IDLE, HDR, PAYLOAD; 2-bit byte counter hcnt.
  - IDLE → HDR when rxbuffer_pktavail = 1 (header queue not empty). hcnt = 0.
  - HDR: each rden emits port[31-8*hcnt -: 8].
    - datavld is high the cycle after rden.
    - After hcnt = 3 is emitted, go to PAYLOAD.
  - PAYLOAD: each rden reads the RAM at rd_ptr (sync read), rd_ptr+1; data/eop/datavld are valid the next cycle.
    - When the read entry has eop = 1: pop the header queue; go to IDLE on the cycle the eop byte is presented.
  - Read latency is exactly 1 cycle for both header and payload bytes. rden may toggle arbitrarily.
  - datavld = 0 on any cycle following no rden.
  - rden while IDLE with no packet available: ignored, datavld stays 0.
  - The read side never crosses commit_ptr; only committed bytes are readable.
- Simultaneous events:
  - A header-queue push and pop in the same cycle are both honoured; occupancy is unchanged.
  - A commit and a read on the same cycle are both honoured.
  - A rewind never affects committed data or rd_ptr.
- pktavail is combinational from header-queue occupancy (not empty).

Decomposition:
- Shared package mwrxpkt_pkg contains:
  - HDR_BYTES = 4.
  - Pointer width function/constant (ADDRWIDTH+1).
  - FSM state enum {IDLE, HDR, PAYLOAD}.
- One sub-module: mwrxpktram, a simple dual-port RAM.
  - Width DATAWIDTH+1, depth 2^ADDRWIDTH.
  - Synchronous write and synchronous read, both on rxclk.
- The header queue is a small register array inside the top module.

Test Plan:
- Port 0x1234ABCD, 3-byte payload 0x11,0x22,0x33 good, rden held high → output 0x12,0x34,0xAB,0xCD,0x11,0x22,0x33; eop only on 0x33; pktavail drops after pop.
- Packet with rxerr=1 on EOP → nothing emitted, rxdrop_cnt = 1, wr_ptr returns to commit_ptr. A following good packet is emitted intact.
- 5 good back-to-back packets with no reads (HDRQ depth 4) → 5th dropped, rxdrop_cnt = 1. Reading all 4 returns ports/payloads in order.
- 2100-byte packet with ADDRWIDTH=11 → dropped on full, rxdrop_cnt+1. Next 100-byte packet is accepted and emitted correctly.
- rden toggling 1,0,1,0 during HDR/PAYLOAD → datavld mirrors rden delayed 1 cycle; byte order is preserved.
- Assert rxrst_n low mid-packet and mid-read → all outputs 0 immediately. After release, pktavail = 0 and the next packet is emitted correctly.
